// File: rtl/tagged_flow_buffer.sv
// Multi-flow tagged input stage: one shared write port, one FIFO per flow, arbitrated merge onto one tagged output.
// Latency: a token written at edge N is issued no earlier than edge N+1; in_full[f] back-pressures per flow, out_full stalls issue.

module tfb_fifo #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_dat,
    input  logic          i_pop,
    output logic [DW-1:0] o_head_dat,
    output logic [CW-1:0] o_count
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Caller guarantees push only when not full and pop only when not empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
endmodule

module tagged_flow_buffer #(
    parameter  int FLUX     = 4,
    parameter  int DEPTH    = 16,
    parameter  int DATA_W   = 8,
    parameter  int ARB_MODE = 0,
    localparam int TAG_W    = $clog2(FLUX),
    localparam int W        = TAG_W + DATA_W,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    in_din,
    input  logic            in_write,
    output logic [FLUX-1:0] in_full,
    output logic [W-1:0]    out_din,
    output logic            out_write,
    input  logic            out_full,
    output logic [FLUX-1:0] empty,
    output logic [FLUX-1:0] ovf_err,
    output logic            tag_err,
    input  logic            err_clr
);
    logic [TAG_W-1:0]  w_tag;
    logic              w_tag_ok;
    logic [FLUX-1:0]   w_full;
    logic [FLUX-1:0]   w_empty;
    logic [FLUX-1:0]   w_push;
    logic [FLUX-1:0]   w_pop;
    logic [FLUX-1:0]   w_ovf_new;
    logic [CW-1:0]     w_count [FLUX];
    logic [DATA_W-1:0] w_head  [FLUX];
    logic              w_grant_vld;
    logic [TAG_W-1:0]  w_grant;
    logic [DATA_W-1:0] w_grant_dat;
    logic              w_issue;
    int                w_idx;

    logic [W-1:0]      r_out_din;
    logic              r_out_write;
    logic [FLUX-1:0]   r_ovf_err;
    logic              r_tag_err;
    logic [TAG_W-1:0]  r_rr_ptr;

    assign w_tag    = in_din[W-1:DATA_W];
    assign w_tag_ok = (32'(w_tag) < FLUX);

    for (genvar f = 0; f < FLUX; f++) begin : g_flow
        tfb_fifo #(.DW(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .i_push     (w_push[f]),
            .i_push_dat (in_din[DATA_W-1:0]),
            .i_pop      (w_pop[f]),
            .o_head_dat (w_head[f]),
            .o_count    (w_count[f])
        );
    end

    always_comb begin
        w_full    = '0;
        w_empty   = '0;
        w_push    = '0;
        w_ovf_new = '0;
        w_pop     = '0;
        for (int f = 0; f < FLUX; f++) begin
            w_full[f]    = (w_count[f] == CW'(DEPTH));
            w_empty[f]   = (w_count[f] == '0);
            w_push[f]    = in_write && w_tag_ok && (w_tag == TAG_W'(f)) && !w_full[f];
            w_ovf_new[f] = in_write && w_tag_ok && (w_tag == TAG_W'(f)) && w_full[f];
            w_pop[f]     = w_issue && (w_grant == TAG_W'(f));
        end
    end

    // Later loop iterations overwrite earlier ones, so iterate from lowest priority to highest.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_grant_dat = '0;
        w_idx       = 0;
        if (ARB_MODE == 1) begin
            for (int i = FLUX - 1; i >= 0; i--) begin
                if (!w_empty[i]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = TAG_W'(i);
                    w_grant_dat = w_head[i];
                end
            end
        end else begin
            for (int i = FLUX; i >= 1; i--) begin
                w_idx = (int'(r_rr_ptr) + i) % FLUX;
                if (!w_empty[w_idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = TAG_W'(w_idx);
                    w_grant_dat = w_head[w_idx];
                end
            end
        end
    end

    assign w_issue = w_grant_vld && !out_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_write <= 1'b0;
            r_out_din   <= '0;
            r_ovf_err   <= '0;
            r_tag_err   <= 1'b0;
            r_rr_ptr    <= TAG_W'(FLUX - 1);
        end else begin
            r_out_write <= w_issue;
            if (w_issue) begin
                r_out_din <= {w_grant, w_grant_dat};
                r_rr_ptr  <= w_grant;
            end
            // A fresh error on the clearing edge wins over the clear.
            r_ovf_err <= (err_clr ? '0 : r_ovf_err) | w_ovf_new;
            r_tag_err <= (r_tag_err && !err_clr) || (in_write && !w_tag_ok);
        end
    end

    assign in_full   = w_full;
    assign empty     = w_empty;
    assign out_din   = r_out_din;
    assign out_write = r_out_write;
    assign ovf_err   = r_ovf_err;
    assign tag_err   = r_tag_err;
endmodule

// File: tb/tb_tagged_flow_buffer.sv
// Bench for tagged_flow_buffer: a round-robin and a fixed-priority instance share stimulus,
// per-flow payload queues and per-instance tag-order queues are checked as tokens emerge.
module tb_tagged_flow_buffer;
    localparam int FLUX = 4;
    localparam int DEPTH = 16;
    localparam int DATA_W = 8;
    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in_din = '0;
    logic         in_write = 1'b0;
    logic         out_full = 1'b0;
    logic         err_clr = 1'b0;

    logic [3:0]   in_full0, empty0, ovf0, in_full1, empty1, ovf1;
    logic [W-1:0] out_din0, out_din1;
    logic         out_write0, out_write1, tag_err0, tag_err1;

    tagged_flow_buffer #(.FLUX(FLUX), .DEPTH(DEPTH), .DATA_W(DATA_W), .ARB_MODE(0)) u_dut_rr (
        .clk(clk), .rst(rst), .in_din(in_din), .in_write(in_write), .in_full(in_full0),
        .out_din(out_din0), .out_write(out_write0), .out_full(out_full), .empty(empty0),
        .ovf_err(ovf0), .tag_err(tag_err0), .err_clr(err_clr));

    tagged_flow_buffer #(.FLUX(FLUX), .DEPTH(DEPTH), .DATA_W(DATA_W), .ARB_MODE(1)) u_dut_fp (
        .clk(clk), .rst(rst), .in_din(in_din), .in_write(in_write), .in_full(in_full1),
        .out_din(out_din1), .out_write(out_write1), .out_full(out_full), .empty(empty1),
        .ovf_err(ovf1), .tag_err(tag_err1), .err_clr(err_clr));

    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_bad = 0;
    int         n_pulses = 0;
    int         sent = 0;
    bit         order_en = 1'b0;
    logic       prev_full = 1'b0;
    logic [1:0] mt;
    logic [1:0] tg;
    logic [7:0] sb_q [4][$];
    logic [1:0] tq0[$];
    logic [1:0] tq1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pending();
        return sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size()
               + tq0.size() + tq1.size();
    endfunction

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (k < 400 && pending() != 0) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tag, pending(), 0);
        step();
    endtask

    always @(posedge clk) prev_full <= out_full;

    always @(negedge clk) begin
        if (out_write0) begin
            n_pulses++;
            mt = out_din0[9:8];
            chk("issue_while_full", prev_full, 0);
            chk("tok_expected", sb_q[mt].size() > 0, 1);
            if (sb_q[mt].size() > 0) chk("payload", out_din0[7:0], sb_q[mt].pop_front());
            if (order_en) begin
                chk("rr_len", tq0.size() > 0, 1);
                if (tq0.size() > 0) chk("rr_order", mt, tq0.pop_front());
            end
        end
        if (out_write1 && order_en) begin
            chk("fp_len", tq1.size() > 0, 1);
            if (tq1.size() > 0) chk("fp_order", out_din1[9:8], tq1.pop_front());
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) step();
        rst = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t1_out_write", out_write0, 0);
        end
        chk("t1_empty", empty0, 4'hF);
        chk("t1_in_full", in_full0, 4'h0);
        chk("t1_ovf", ovf0, 4'h0);
        chk("t1_tag_err", tag_err0, 0);
        chk("t1_out_din", out_din0, 0);
        chk("t1_empty_fp", empty1, 4'hF);
        step();

        // One-edge latency, no bypass
        in_din = {2'd0, 8'hA5};
        in_write = 1'b1;
        sb_q[0].push_back(8'hA5);
        @(posedge clk);
        #1 in_write = 1'b0;
        @(negedge clk);
        chk("lat_same_edge", out_write0, 0);
        @(negedge clk);
        chk("lat_next_edge", out_write0, 1);
        step();

        // Long single-flow stream
        n_pulses = 0;
        for (int i = 0; i < 529; i++) begin
            in_din = {2'd0, 8'(i * 7 + 3)};
            in_write = 1'b1;
            sb_q[0].push_back(8'(i * 7 + 3));
            step();
        end
        in_write = 1'b0;
        drain("t2_drain");
        chk("t2_pulses", n_pulses, 529);

        // Fill flow 2, overflow, clear
        out_full = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_din = {2'd2, 8'(8'h80 + i)};
            in_write = 1'b1;
            sb_q[2].push_back(8'(8'h80 + i));
            step();
        end
        in_write = 1'b0;
        chk("t3_full", in_full0, 4'b0100);
        chk("t3_empty", empty0, 4'b1011);
        chk("t3_ovf_before", ovf0, 4'h0);
        in_din = {2'd2, 8'hEE};
        in_write = 1'b1;
        step();
        in_write = 1'b0;
        chk("t3_ovf_set", ovf0, 4'b0100);
        chk("t3_full_held", in_full0, 4'b0100);
        in_din = {2'd2, 8'hEF};
        in_write = 1'b1;
        err_clr = 1'b1;
        step();
        in_write = 1'b0;
        chk("t3_ovf_beats_clr", ovf0, 4'b0100);
        step();
        err_clr = 1'b0;
        chk("t3_ovf_clr", ovf0, 4'h0);
        out_full = 1'b0;
        drain("t3_drain");
        chk("t3_empty_after", empty0, 4'hF);
        chk("t3_full_after", in_full0, 4'h0);

        // Arbitration order with 3 tokens per flow preloaded
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        out_full = 1'b1;
        order_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int f = 0; f < 4; f++) begin
                in_din = {2'(f), 8'(r * 16 + f)};
                in_write = 1'b1;
                sb_q[f].push_back(8'(r * 16 + f));
                tq0.push_back(2'(f));
                step();
            end
        end
        in_write = 1'b0;
        for (int f = 0; f < 4; f++) for (int r = 0; r < 3; r++) tq1.push_back(2'(f));
        out_full = 1'b0;
        drain("t45_drain");
        order_en = 1'b0;

        // Two flows with toggling downstream backpressure
        n_pulses = 0;
        sent = 0;
        for (int c = 0; c < 200; c++) begin
            out_full = c[1];
            tg = c[0] ? 2'd3 : 2'd1;
            if (!in_full0[tg]) begin
                in_din = {tg, 8'(c)};
                in_write = 1'b1;
                sb_q[tg].push_back(8'(c));
                sent++;
            end else begin
                in_write = 1'b0;
            end
            step();
        end
        in_write = 1'b0;
        out_full = 1'b0;
        drain("t6_drain");
        chk("t6_pulses", n_pulses, sent);
        chk("t6_ovf", ovf0, 4'h0);

        // Reset in the middle of a stream
        for (int i = 0; i < 6; i++) begin
            in_din = {2'd3, 8'(8'h40 + i)};
            in_write = 1'b1;
            sb_q[3].push_back(8'(8'h40 + i));
            step();
        end
        in_write = 1'b0;
        rst = 1'b0;
        for (int f = 0; f < 4; f++) sb_q[f].delete();
        #1;
        chk("rst_out_write", out_write0, 0);
        chk("rst_empty", empty0, 4'hF);
        chk("rst_in_full", in_full0, 4'h0);
        chk("rst_out_din", out_din0, 0);
        step();
        step();
        rst = 1'b1;
        repeat (10) step();
        chk("rst_idle_empty", empty0, 4'hF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
